// File: rtl/gol_field_stepper_pkg.sv
// Shared types and constants for the Game-of-Life field stepper.
// Rule masks: bit n set means the rule fires with exactly n live neighbours.
package gol_field_stepper_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      COMMIT = 2'd2
   } stepper_state_t;

   localparam logic [8:0] GOL_BIRTH_MASK   = 9'b000001000;
   localparam logic [8:0] GOL_SURVIVE_MASK = 9'b000001100;

   localparam int GOL_FIELD_W = 16;
   localparam int GOL_FIELD_H = 16;

   // Masks are zero-extended so every 4-bit count, including 9..15, is a legal index.
   function automatic logic gol_rule(input logic alive, input logic [3:0] nbr_cnt);
      logic [15:0] w_birth;
      logic [15:0] w_survive;
      w_birth   = {7'd0, GOL_BIRTH_MASK};
      w_survive = {7'd0, GOL_SURVIVE_MASK};
      return alive ? w_survive[nbr_cnt] : w_birth[nbr_cnt];
   endfunction

endpackage

// File: rtl/gol_field_stepper_row_next.sv
// Combinational next-generation row from three source rows; zero latency, no flow control.
// Column wrap is applied here, so column -1 is FIELD_W-1 and column FIELD_W is 0.
module gol_row_next
   import gol_field_stepper_pkg::*;
#(
   parameter int FIELD_W = GOL_FIELD_W
) (
   input  logic [FIELD_W-1:0] i_row_above,
   input  logic [FIELD_W-1:0] i_row_cur,
   input  logic [FIELD_W-1:0] i_row_below,
   output logic [FIELD_W-1:0] o_row_next
);

   for (genvar c = 0; c < FIELD_W; c++) begin : g_col
      localparam int CL = (c == 0) ? FIELD_W - 1 : c - 1;
      localparam int CR = (c == FIELD_W - 1) ? 0 : c + 1;

      logic [3:0] w_cnt;

      assign w_cnt = {3'd0, i_row_above[CL]} + {3'd0, i_row_above[c]} + {3'd0, i_row_above[CR]}
                   + {3'd0, i_row_cur[CL]}                             + {3'd0, i_row_cur[CR]}
                   + {3'd0, i_row_below[CL]} + {3'd0, i_row_below[c]} + {3'd0, i_row_below[CR]};

      assign o_row_next[c] = gol_rule(i_row_cur[c], w_cnt);
   end

endmodule

// File: rtl/gol_field_stepper.sv
// Game-of-Life stepper: one generation per i_go, done FIELD_H+2 cycles after go.
// No queuing: i_go and i_load_en are dropped while busy; load beats go in IDLE.
module gol_field_stepper
   import gol_field_stepper_pkg::*;
#(
   parameter int FIELD_W = GOL_FIELD_W,
   parameter int FIELD_H = GOL_FIELD_H,
   parameter int GEN_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_go,
   input  logic                         i_load_en,
   input  logic [$clog2(FIELD_H)-1:0]   i_load_row,
   input  logic [FIELD_W-1:0]           i_load_data,
   output logic                         o_NFI_allowed,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [FIELD_W*FIELD_H-1:0]   o_field,
   output logic [GEN_W-1:0]             o_gen_count
);

   localparam int             RW       = $clog2(FIELD_H);
   localparam logic [RW-1:0]  LAST_ROW = RW'(FIELD_H - 1);
   localparam logic [RW:0]    H_LIM    = FIELD_H[RW:0];

   stepper_state_t     r_state;
   stepper_state_t     w_state_nxt;
   logic [RW-1:0]      r_row;
   logic [FIELD_W-1:0] r_cur [FIELD_H];
   logic [FIELD_W-1:0] r_nxt [FIELD_H];
   logic [GEN_W-1:0]   r_gen;
   logic               r_done;

   logic               w_load;
   logic               w_start;
   logic               w_calc;
   logic               w_commit;
   logic [RW-1:0]      w_row_up;
   logic [RW-1:0]      w_row_dn;
   logic [FIELD_W-1:0] w_next_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_start     = 1'b0;
      w_calc      = 1'b0;
      w_commit    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_load_en) begin
               w_load = 1'b1;
            end else if (i_go) begin
               w_start     = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_calc = 1'b1;
            if (r_row == LAST_ROW) w_state_nxt = COMMIT;
         end
         COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Row wrap lives here; column wrap lives in gol_row_next.
   assign w_row_up = (r_row == '0)       ? LAST_ROW : r_row - RW'(1);
   assign w_row_dn = (r_row == LAST_ROW) ? '0       : r_row + RW'(1);

   gol_row_next #(
      .FIELD_W (FIELD_W)
   ) u_row_next (
      .i_row_above (r_cur[w_row_up]),
      .i_row_cur   (r_cur[r_row]),
      .i_row_below (r_cur[w_row_dn]),
      .o_row_next  (w_next_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < FIELD_H; r++) begin
            r_cur[r] <= '0;
            r_nxt[r] <= '0;
         end
         r_row  <= '0;
         r_gen  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_load && ({1'b0, i_load_row} < H_LIM)) begin
            r_cur[i_load_row] <= i_load_data;
         end
         if (w_start) begin
            r_row <= '0;
         end
         if (w_calc) begin
            r_nxt[r_row] <= w_next_row;
            if (r_row != LAST_ROW) r_row <= r_row + RW'(1);
         end
         if (w_commit) begin
            for (int r = 0; r < FIELD_H; r++) begin
               r_cur[r] <= r_nxt[r];
            end
            r_row  <= '0;
            r_gen  <= r_gen + GEN_W'(1);
            r_done <= 1'b1;
         end
      end
   end

   for (genvar r = 0; r < FIELD_H; r++) begin : g_out
      assign o_field[r*FIELD_W +: FIELD_W] = r_cur[r];
   end

   assign o_NFI_allowed = (r_state == IDLE);
   assign o_busy        = (r_state == CALC) || (r_state == COMMIT);
   assign o_done        = r_done;
   assign o_gen_count   = r_gen;

endmodule

// File: tb/tb_gol_field_stepper.sv
// Bench for gol_field_stepper: vector table of patterns plus hand-written busy/reset sequences.
`timescale 1ns/1ps
module tb_gol_field_stepper;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int GW = 16;
   localparam int FB = W * H;

   typedef logic [FB-1:0] field_t;
   typedef struct {
      string  name;
      field_t init;
      int     ngen;
      field_t exp;
   } vec_t;
   typedef struct {
      field_t        field;
      logic [GW-1:0] gen;
   } sb_t;

   logic          clk         = 1'b0;
   logic          rst_n       = 1'b0;
   logic          i_go        = 1'b0;
   logic          i_load_en   = 1'b0;
   logic [3:0]    i_load_row  = '0;
   logic [W-1:0]  i_load_data = '0;
   logic          o_NFI_allowed;
   logic          o_busy;
   logic          o_done;
   field_t        o_field;
   logic [GW-1:0] o_gen_count;

   int            checks   = 0;
   int            failures = 0;
   sb_t           sb_q[$];
   field_t        model;
   logic [GW-1:0] exp_gen;

   gol_field_stepper #(
      .FIELD_W (W),
      .FIELD_H (H),
      .GEN_W   (GW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_go          (i_go),
      .i_load_en     (i_load_en),
      .i_load_row    (i_load_row),
      .i_load_data   (i_load_data),
      .o_NFI_allowed (o_NFI_allowed),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_field       (o_field),
      .o_gen_count   (o_gen_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input field_t act, input field_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic field_t put(input field_t f, input int r, input int c);
      field_t t;
      t = f;
      t[((r % H + H) % H) * W + ((c % W + W) % W)] = 1'b1;
      return t;
   endfunction

   // Reference generation: B3/S23 on a torus, counted cell by cell.
   function automatic field_t model_step(input field_t f);
      field_t n;
      int     cnt;
      n = '0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0)
                     cnt += int'(f[((r + dr + H) % H) * W + ((c + dc + W) % W)]);
               end
            end
            n[r*W + c] = (cnt == 3) || (f[r*W + c] && cnt == 2);
         end
      end
      return n;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      i_go = 1'b0;
      i_load_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model = '0;
      exp_gen = '0;
      sb_q.delete();
   endtask

   task automatic load_field(input field_t f);
      for (int r = 0; r < H; r++) begin
         i_load_en   = 1'b1;
         i_load_row  = 4'(r);
         i_load_data = f[r*W +: W];
         tick();
      end
      i_load_en = 1'b0;
      model = f;
   endtask

   task automatic run_go(input string nm);
      int  cyc;
      bit  got;
      sb_t e;
      e.field = model_step(model);
      e.gen   = exp_gen + GW'(1);
      model   = e.field;
      exp_gen = e.gen;
      sb_q.push_back(e);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc <= 40) begin
         if (o_done) got = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      chk({nm, "_latency"}, field_t'(cyc), field_t'(H + 2));
      e = sb_q.pop_front();
      chk({nm, "_field"}, o_field, e.field);
      chk({nm, "_gen"}, field_t'(o_gen_count), field_t'(e.gen));
      chk({nm, "_nfi_at_done"}, field_t'(o_NFI_allowed), field_t'(1));
      tick();
      chk({nm, "_done_width"}, field_t'(o_done), field_t'(0));
   endtask

   initial begin
      vec_t   vecs[7];
      field_t bh, bv, wh, wv, blk, g0, g4, snap;
      int     ndone, done_cyc, bad;

      bh  = put(put(put('0, 4, 4), 4, 5), 4, 6);
      bv  = put(put(put('0, 3, 5), 4, 5), 5, 5);
      wh  = put(put(put('0, 0, 15), 0, 0), 0, 1);
      wv  = put(put(put('0, 15, 0), 0, 0), 1, 0);
      blk = put(put(put(put('0, 7, 7), 7, 8), 8, 7), 8, 8);
      g0  = put(put(put(put(put('0, 0, 1), 1, 2), 2, 0), 2, 1), 2, 2);
      g4  = put(put(put(put(put('0, 1, 2), 2, 3), 3, 1), 3, 2), 3, 3);

      vecs[0] = '{"blinker_1",    bh,  1,  bv};
      vecs[1] = '{"blinker_2",    bh,  2,  bh};
      vecs[2] = '{"blinker_wrap", wh,  1,  wv};
      vecs[3] = '{"block",        blk, 1,  blk};
      vecs[4] = '{"empty",        '0,  2,  '0};
      vecs[5] = '{"glider_4",     g0,  4,  g4};
      vecs[6] = '{"glider_64",    g0,  64, g0};

      do_reset();
      chk("reset_field", o_field, '0);
      chk("reset_gen", field_t'(o_gen_count), '0);
      chk("reset_nfi", field_t'(o_NFI_allowed), field_t'(1));
      chk("reset_busy", field_t'(o_busy), '0);
      chk("reset_done", field_t'(o_done), '0);

      foreach (vecs[i]) begin
         do_reset();
         load_field(vecs[i].init);
         chk({vecs[i].name, "_loaded"}, o_field, vecs[i].init);
         for (int g = 0; g < vecs[i].ngen; g++) run_go(vecs[i].name);
         chk({vecs[i].name, "_final"}, o_field, vecs[i].exp);
         chk({vecs[i].name, "_final_gen"}, field_t'(o_gen_count), field_t'(vecs[i].ngen));
      end

      // Repeated go while busy: only the first one counts.
      do_reset();
      load_field(bh);
      ndone = 0;
      done_cyc = -1;
      bad = 0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (o_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
         end
         if ((c <= H + 1) == o_NFI_allowed) bad++;
         if ((c <= H + 1) != o_busy) bad++;
         i_go = (c == 3 || c == H + 1);
         tick();
      end
      i_go = 1'b0;
      chk("busy_go_done_count", field_t'(ndone), field_t'(1));
      chk("busy_go_done_cycle", field_t'(done_cyc), field_t'(H + 2));
      chk("busy_go_nfi_busy_window", field_t'(bad), '0);
      chk("busy_go_field", o_field, bv);
      chk("busy_go_gen", field_t'(o_gen_count), field_t'(1));

      // Load during CALC is dropped; field stays stable until commit.
      do_reset();
      load_field(bh);
      snap = '0;
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      for (int c = 1; c < H + 2; c++) begin
         if (c == 10) snap = o_field;
         i_load_en   = (c == 5);
         i_load_row  = 4'd4;
         i_load_data = '1;
         tick();
      end
      i_load_en = 1'b0;
      chk("busy_load_calc_stable", snap, bh);
      chk("busy_load_done", field_t'(o_done), field_t'(1));
      chk("busy_load_field", o_field, bv);
      tick();

      // Load and go together in IDLE: load wins, no step.
      i_load_en   = 1'b1;
      i_go        = 1'b1;
      i_load_row  = 4'd0;
      i_load_data = 16'h0001;
      tick();
      i_load_en = 1'b0;
      i_go = 1'b0;
      chk("collide_busy", field_t'(o_busy), '0);
      chk("collide_nfi", field_t'(o_NFI_allowed), field_t'(1));
      chk("collide_field", o_field, put(bv, 0, 0));
      ndone = 0;
      for (int c = 0; c < H + 6; c++) begin
         if (o_done || o_busy) ndone++;
         tick();
      end
      chk("collide_no_step", field_t'(ndone), '0);
      chk("collide_gen", field_t'(o_gen_count), field_t'(1));

      // Asynchronous reset in the middle of CALC.
      do_reset();
      load_field(bh);
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      repeat (7) tick();
      chk("midcalc_busy_before", field_t'(o_busy), field_t'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("midcalc_rst_field", o_field, '0);
      chk("midcalc_rst_gen", field_t'(o_gen_count), '0);
      chk("midcalc_rst_nfi", field_t'(o_NFI_allowed), field_t'(1));
      chk("midcalc_rst_busy", field_t'(o_busy), '0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      bad = 0;
      for (int c = 0; c < H + 6; c++) begin
         if (o_done) ndone++;
         if (!o_NFI_allowed) bad++;
         tick();
      end
      chk("midcalc_no_done", field_t'(ndone), '0);
      chk("midcalc_stays_idle", field_t'(bad), '0);
      chk("midcalc_field_after", o_field, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
